// File: rtl/branch_seq_pkg.sv
// Shared definitions for the branch sequencer: opcode encodings, FSM state
// encoding and default operand width.
package branch_seq_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] OP_BLTZ     = 4'b0010;
  localparam logic [3:0] OP_BGEZ     = 4'b0011;
  localparam logic [3:0] OP_BEQ      = 4'b1000;
  localparam logic [3:0] OP_BEQ_ALT  = 4'b1001;
  localparam logic [3:0] OP_BNE      = 4'b1010;
  localparam logic [3:0] OP_BNE_ALT  = 4'b1011;
  localparam logic [3:0] OP_BLEZ     = 4'b1100;
  localparam logic [3:0] OP_BGTZ     = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  // beq/bne are the only ops that compare against rt; all others compare to zero
  function automatic logic uses_rt(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/branch_seq_cond.sv
// Combinational branch-condition evaluator: maps opcode plus the registered
// sign (si) and zero (ze) flags to a decision and a legality flag.
module branch_cond
  import branch_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       si,
  input  logic       ze,
  output logic       cond,
  output logic       legal
);

  // Decode the opcode into the branch decision
  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (op)
      OP_BLTZ:                cond = si;
      OP_BGEZ:                cond = ~si;
      OP_BEQ, OP_BEQ_ALT:     cond = ze;
      OP_BNE, OP_BNE_ALT:     cond = ~ze;
      OP_BLEZ:                cond = si | ze;
      OP_BGTZ:                cond = ~(si | ze);
      default:                legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq.sv
// Multi-cycle branch sequencer: IDLE -> CMP -> EVAL -> DONE.
// Latches a branch request, compares rs against rt (or zero), computes the
// branch target and pulses the PC write strobe when the branch is taken.
// Optional statistics counters are enabled by defining BRANCH_SEQ_STATS_EN.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef BRANCH_SEQ_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] pc_plus4,
`ifdef BRANCH_SEQ_STATS_EN
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_not_taken,
`endif
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic [DATA_W-1:0] target,
  output logic              pc_we,
  output logic              illegal
);

  state_t            r_state;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_rt;
  logic [15:0]       r_imm;
  logic [DATA_W-1:0] r_pc;
  logic              r_si;
  logic              r_ze;
  logic [DATA_W-1:0] r_target;
  logic              r_busy;
  logic              r_done;
  logic              r_taken;
  logic              r_pc_we;
  logic              r_illegal;

  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_offset;
  logic [DATA_W-1:0] w_target;
  logic              w_cond;
  logic              w_legal;

  // Subtraction wraps modulo 2^DATA_W; only equality is taken from it
  assign w_diff   = r_rs - r_rt;
  // Word offset: sign-extend the 16-bit immediate and scale by 4
  assign w_offset = {{(DATA_W-18){r_imm[15]}}, r_imm, 2'b00};
  assign w_target = r_pc + w_offset;

  branch_cond u_cond (
    .op    (r_op),
    .si    (r_si),
    .ze    (r_ze),
    .cond  (w_cond),
    .legal (w_legal)
  );

  // Sequencer FSM with registered datapath and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_si      <= 1'b0;
      r_ze      <= 1'b0;
      r_target  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_taken   <= 1'b0;
      r_pc_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_pc_we   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_op    <= op;
            r_rs    <= rs_val;
            r_rt    <= uses_rt(op) ? rt_val : '0;
            r_imm   <= imm;
            r_pc    <= pc_plus4;
            r_busy  <= 1'b1;
            r_state <= CMP;
          end
        end
        CMP: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            // Sign comes from rs itself, not from the difference
            r_si     <= r_rs[DATA_W-1];
            r_ze     <= (w_diff == '0);
            r_target <= w_target;
            r_state  <= EVAL;
          end
        end
        EVAL: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_taken   <= w_cond & w_legal;
            r_pc_we   <= w_cond & w_legal;
            r_illegal <= ~w_legal;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // flush is ignored here: the PC write is already on its way out
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign taken   = r_taken;
  assign target  = r_target;
  assign pc_we   = r_pc_we;
  assign illegal = r_illegal;

`ifdef BRANCH_SEQ_STATS_EN
  logic [CNT_W-1:0] r_stat_taken;
  logic [CNT_W-1:0] r_stat_not_taken;

  // Saturating decision counters; clear has priority over an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_taken     <= '0;
      r_stat_not_taken <= '0;
    end else if (stat_clr) begin
      r_stat_taken     <= '0;
      r_stat_not_taken <= '0;
    end else if (r_done && !r_illegal) begin
      if (r_taken) begin
        if (r_stat_taken != '1) r_stat_taken <= r_stat_taken + 1'b1;
      end else begin
        if (r_stat_not_taken != '1) r_stat_not_taken <= r_stat_not_taken + 1'b1;
      end
    end
  end

  assign stat_taken     = r_stat_taken;
  assign stat_not_taken = r_stat_not_taken;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Directed self-checking bench for branch_seq. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// Define BRANCH_SEQ_STATS_EN to also exercise the statistics counters.
module tb_branch_seq;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              flush;
  logic [3:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [15:0]       imm;
  logic [DATA_W-1:0] pc_plus4;
  logic              busy;
  logic              done;
  logic              taken;
  logic [DATA_W-1:0] target;
  logic              pc_we;
  logic              illegal;
`ifdef BRANCH_SEQ_STATS_EN
  logic              stat_clr;
  logic [1:0]        stat_taken;
  logic [1:0]        stat_not_taken;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  branch_seq #(
    .DATA_W (DATA_W)
`ifdef BRANCH_SEQ_STATS_EN
    ,
    .CNT_W  (2)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .flush          (flush),
    .op             (op),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .imm            (imm),
    .pc_plus4       (pc_plus4),
`ifdef BRANCH_SEQ_STATS_EN
    .stat_clr       (stat_clr),
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken),
`endif
    .busy           (busy),
    .done           (done),
    .taken          (taken),
    .target         (target),
    .pc_we          (pc_we),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // One full branch: start presented before edge 1, outputs read in the
  // DONE cycle (after edge 3) and again after edge 4.
  task automatic run_branch(input logic [3:0] b_op, input logic [31:0] b_rs,
                            input logic [31:0] b_rt, input logic [15:0] b_imm,
                            input logic [31:0] b_pc,
                            output logic o_done, output logic o_taken,
                            output logic o_pc_we, output logic o_ill,
                            output logic [31:0] o_target, output logic o_done_after);
    @(negedge clk);
    start = 1'b1; op = b_op; rs_val = b_rs; rt_val = b_rt; imm = b_imm; pc_plus4 = b_pc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    o_done = done; o_taken = taken; o_pc_we = pc_we; o_ill = illegal; o_target = target;
    @(negedge clk);
    o_done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (taken !== 1'b0)   begin n_fail++; $display("FAIL reset_taken got=%b exp=0", taken); end
    n_cmp++; if (pc_we !== 1'b0)   begin n_fail++; $display("FAIL reset_pc_we got=%b exp=0", pc_we); end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    n_cmp++; if (target !== 32'h0) begin n_fail++; $display("FAIL reset_target got=%h exp=0", target); end
    rst_n = 1'b1;
  endtask

  task automatic test_beq();
    logic d, t, w, il, da;
    logic [31:0] tg;
    run_branch(4'b1000, 32'h10, 32'h10, 16'h0004, 32'h0040_0008, d, t, w, il, tg, da);
    n_cmp++; if (d !== 1'b1)            begin n_fail++; $display("FAIL beq_done got=%b exp=1", d); end
    n_cmp++; if (t !== 1'b1)            begin n_fail++; $display("FAIL beq_taken got=%b exp=1", t); end
    n_cmp++; if (w !== 1'b1)            begin n_fail++; $display("FAIL beq_pc_we got=%b exp=1", w); end
    n_cmp++; if (il !== 1'b0)           begin n_fail++; $display("FAIL beq_illegal got=%b exp=0", il); end
    n_cmp++; if (tg !== 32'h0040_0018)  begin n_fail++; $display("FAIL beq_target got=%h exp=00400018", tg); end
    n_cmp++; if (da !== 1'b0)           begin n_fail++; $display("FAIL beq_done_one_cycle got=%b exp=0", da); end
    run_branch(4'b1001, 32'h10, 32'h11, 16'h0004, 32'h0040_0008, d, t, w, il, tg, da);
    n_cmp++; if (t !== 1'b0)            begin n_fail++; $display("FAIL beq_ne_taken got=%b exp=0", t); end
  endtask

  task automatic test_bne();
    logic d, t, w, il, da;
    logic [31:0] tg;
    run_branch(4'b1010, 32'd5, 32'd5, 16'hFFFF, 32'h0000_0100, d, t, w, il, tg, da);
    n_cmp++; if (d !== 1'b1)      begin n_fail++; $display("FAIL bne_done got=%b exp=1", d); end
    n_cmp++; if (t !== 1'b0)      begin n_fail++; $display("FAIL bne_taken got=%b exp=0", t); end
    n_cmp++; if (w !== 1'b0)      begin n_fail++; $display("FAIL bne_pc_we got=%b exp=0", w); end
    n_cmp++; if (tg !== 32'hFC)   begin n_fail++; $display("FAIL bne_target got=%h exp=000000fc", tg); end
    run_branch(4'b1011, 32'd5, 32'd6, 16'h8000, 32'h0004_0000, d, t, w, il, tg, da);
    n_cmp++; if (t !== 1'b1 || w !== 1'b1) begin n_fail++; $display("FAIL bne_diff_taken got=%b/%b exp=1/1", t, w); end
    n_cmp++; if (tg !== 32'h0002_0000)     begin n_fail++; $display("FAIL bne_neg_target got=%h exp=00020000", tg); end
  endtask

  task automatic test_sign_zero();
    logic [3:0]  ops [10];
    logic [31:0] rss [10];
    logic [31:0] rts [10];
    logic        exp [10];
    logic d, t, w, il, da;
    logic [31:0] tg;
    ops[0] = 4'b0010; rss[0] = 32'h8000_0000; rts[0] = 32'h0; exp[0] = 1'b1; // bltz
    ops[1] = 4'b0011; rss[1] = 32'h8000_0000; rts[1] = 32'h0; exp[1] = 1'b0; // bgez
    ops[2] = 4'b1100; rss[2] = 32'h8000_0000; rts[2] = 32'h0; exp[2] = 1'b1; // blez
    ops[3] = 4'b1110; rss[3] = 32'h8000_0000; rts[3] = 32'h0; exp[3] = 1'b0; // bgtz
    ops[4] = 4'b1100; rss[4] = 32'h0;         rts[4] = 32'h0; exp[4] = 1'b1; // blez
    ops[5] = 4'b1110; rss[5] = 32'h0;         rts[5] = 32'h0; exp[5] = 1'b0; // bgtz
    ops[6] = 4'b0010; rss[6] = 32'h0;         rts[6] = 32'h0; exp[6] = 1'b0; // bltz
    ops[7] = 4'b0011; rss[7] = 32'h0;         rts[7] = 32'h0; exp[7] = 1'b1; // bgez
    ops[8] = 4'b1100; rss[8] = 32'd5;         rts[8] = 32'd5; exp[8] = 1'b0; // blez, rt ignored
    ops[9] = 4'b1110; rss[9] = 32'h7FFF_FFFF; rts[9] = 32'h7FFF_FFFF; exp[9] = 1'b1; // bgtz, rt ignored
    for (int i = 0; i < 10; i++) begin
      run_branch(ops[i], rss[i], rts[i], 16'h0001, 32'h1000, d, t, w, il, tg, da);
      n_cmp++;
      if (t !== exp[i] || w !== exp[i] || d !== 1'b1)
        begin n_fail++; $display("FAIL signzero[%0d] op=%b taken/pc_we/done got=%b/%b/%b exp=%b/%b/1", i, ops[i], t, w, d, exp[i], exp[i]); end
    end
  endtask

  task automatic test_illegal();
    logic d, t, w, il, da;
    logic [31:0] tg;
    run_branch(4'b0001, 32'h0, 32'h0, 16'h0001, 32'h2000, d, t, w, il, tg, da);
    n_cmp++; if (d !== 1'b1)  begin n_fail++; $display("FAIL illegal_done got=%b exp=1", d); end
    n_cmp++; if (il !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got=%b exp=1", il); end
    n_cmp++; if (w !== 1'b0)  begin n_fail++; $display("FAIL illegal_pc_we got=%b exp=0", w); end
    n_cmp++; if (t !== 1'b0)  begin n_fail++; $display("FAIL illegal_taken got=%b exp=0", t); end
    @(negedge clk);
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle got=%b exp=0", illegal); end
  endtask

  task automatic test_back_to_back();
    logic [12:1] got_done, got_busy, got_we;
    @(negedge clk);
    start = 1'b1; op = 4'b1000; rs_val = 32'h7; rt_val = 32'h7; imm = 16'h2; pc_plus4 = 32'h400;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      got_done[k] = done; got_busy[k] = busy; got_we[k] = pc_we;
      if (k == 12) start = 1'b0;
    end
    n_cmp++; if (got_done !== 12'b0100_0100_0100) begin n_fail++; $display("FAIL b2b_done got=%b exp=010001000100", got_done); end
    n_cmp++; if (got_we   !== 12'b0100_0100_0100) begin n_fail++; $display("FAIL b2b_pc_we got=%b exp=010001000100", got_we); end
    n_cmp++; if (got_busy !== 12'b0111_0111_0111) begin n_fail++; $display("FAIL b2b_busy got=%b exp=011101110111", got_busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_released got=%b exp=0", busy); end
  endtask

  task automatic test_flush();
    logic d, t, w, il, da;
    logic [31:0] tg;
    // leave taken=1 from a real taken branch
    run_branch(4'b1000, 32'h1, 32'h1, 16'h0, 32'h0, d, t, w, il, tg, da);
    // flush in EVAL on a branch that would be not taken
    @(negedge clk);
    start = 1'b1; op = 4'b1010; rs_val = 32'h3; rt_val = 32'h3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (done !== 1'b0)  begin n_fail++; $display("FAIL flush_eval_done got=%b exp=0", done); end
    n_cmp++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL flush_eval_pc_we got=%b exp=0", pc_we); end
    n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL flush_eval_busy got=%b exp=0", busy); end
    n_cmp++; if (taken !== 1'b1) begin n_fail++; $display("FAIL flush_eval_taken_held got=%b exp=1", taken); end
    // flush in CMP
    @(negedge clk);
    start = 1'b1; op = 4'b1000; rs_val = 32'h3; rt_val = 32'h3;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_cmp_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_cmp_done got=%b exp=0", done); end
    // start and flush together in IDLE: not accepted
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_flush_idle_busy got=%b exp=0", busy); end
    // flush during DONE: write completes, decision kept
    @(negedge clk);
    start = 1'b1; op = 4'b1010; rs_val = 32'h3; rt_val = 32'h4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    n_cmp++; if (done !== 1'b1 || pc_we !== 1'b1) begin n_fail++; $display("FAIL flush_done_write got=%b/%b exp=1/1", done, pc_we); end
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (taken !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_done_after taken/busy got=%b/%b exp=1/0", taken, busy); end
  endtask

  task automatic test_async_reset();
    logic d, t, w, il, da;
    logic [31:0] tg;
    run_branch(4'b1000, 32'h9, 32'h9, 16'h0010, 32'h0000_8000, d, t, w, il, tg, da);
    @(negedge clk);
    start = 1'b1; op = 4'b1000; rs_val = 32'h9; rt_val = 32'h9;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL async_pre_busy got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL async_busy got=%b exp=0", busy); end
    n_cmp++; if (taken !== 1'b0)   begin n_fail++; $display("FAIL async_taken got=%b exp=0", taken); end
    n_cmp++; if (target !== 32'h0) begin n_fail++; $display("FAIL async_target got=%h exp=0", target); end
    n_cmp++; if (done !== 1'b0 || pc_we !== 1'b0 || illegal !== 1'b0)
      begin n_fail++; $display("FAIL async_strobes got=%b%b%b exp=000", done, pc_we, illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_after_busy got=%b exp=0", busy); end
  endtask

`ifdef BRANCH_SEQ_STATS_EN
  task automatic test_stats();
    logic d, t, w, il, da;
    logic [31:0] tg;
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    n_cmp++; if (stat_taken !== 2'd0 || stat_not_taken !== 2'd0)
      begin n_fail++; $display("FAIL stat_clear got=%0d/%0d exp=0/0", stat_taken, stat_not_taken); end
    for (int i = 0; i < 5; i++)
      run_branch(4'b1000, 32'h1, 32'h1, 16'h0, 32'h0, d, t, w, il, tg, da);
    n_cmp++; if (stat_taken !== 2'd3) begin n_fail++; $display("FAIL stat_taken_sat got=%0d exp=3", stat_taken); end
    run_branch(4'b1010, 32'h1, 32'h1, 16'h0, 32'h0, d, t, w, il, tg, da);
    run_branch(4'b0001, 32'h1, 32'h1, 16'h0, 32'h0, d, t, w, il, tg, da);
    n_cmp++; if (stat_not_taken !== 2'd1) begin n_fail++; $display("FAIL stat_not_taken got=%0d exp=1", stat_not_taken); end
    n_cmp++; if (stat_taken !== 2'd3)     begin n_fail++; $display("FAIL stat_taken_hold got=%0d exp=3", stat_taken); end
    // clear coinciding with the DONE cycle of a taken branch
    @(negedge clk);
    start = 1'b1; op = 4'b1000; rs_val = 32'h2; rt_val = 32'h2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    n_cmp++; if (stat_taken !== 2'd0 || stat_not_taken !== 2'd0)
      begin n_fail++; $display("FAIL stat_clr_wins got=%0d/%0d exp=0/0", stat_taken, stat_not_taken); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 4'b0;
    rs_val = '0; rt_val = '0; imm = '0; pc_plus4 = '0;
`ifdef BRANCH_SEQ_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_beq();
    test_bne();
    test_sign_zero();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef BRANCH_SEQ_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
